// File: rtl/synth_pkg.sv
// Shared types and constants for the voice scheduler.
// Holds the FSM state enum, voice-count defaults and the Q4.4 unity scalar.
package synth_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam int NUM_VOICES_DEF = 8;
    localparam int VIDX_W_DEF     = 3;

    // 1.0 in unsigned Q4.4
    localparam logic [7:0] Q44_UNITY = 8'h10;

endpackage

// File: rtl/voice_cfg_bank.sv
// Double-buffered per-voice configuration (shadow + active banks).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   we_i, widx_i      shadow write strobe and voice index
//   wtw_i, wsc_i      tuning word and Q4.4 mod scalar to write
//   wgate_i           voice gate to write
//   commit_i          copy the whole shadow bank into the active bank
//   act_tw_o          active tuning words, one per voice
//   act_sc_o          active mod scalars, one per voice
//   act_gate_o        active gates, one per voice
//   sh_gate_o         shadow gates (pre-commit view)
module voice_cfg_bank
    import synth_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int VIDX_W     = VIDX_W_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 we_i,
    input  logic [VIDX_W-1:0]                    widx_i,
    input  logic [NUM_BITS-1:0]                  wtw_i,
    input  logic [7:0]                           wsc_i,
    input  logic                                 wgate_i,
    input  logic                                 commit_i,
    output logic [NUM_VOICES-1:0][NUM_BITS-1:0]  act_tw_o,
    output logic [NUM_VOICES-1:0][7:0]           act_sc_o,
    output logic [NUM_VOICES-1:0]                act_gate_o,
    output logic [NUM_VOICES-1:0]                sh_gate_o
);

    logic [NUM_VOICES-1:0][NUM_BITS-1:0] sh_tw_q;
    logic [NUM_VOICES-1:0][7:0]          sh_sc_q;
    logic [NUM_VOICES-1:0]               sh_gate_q;
    logic [NUM_VOICES-1:0][NUM_BITS-1:0] act_tw_q;
    logic [NUM_VOICES-1:0][7:0]          act_sc_q;
    logic [NUM_VOICES-1:0]               act_gate_q;

    // The commit copies the shadow as it was before this edge, so a
    // write landing on the commit cycle only shows up next frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                sh_tw_q[v]    <= '0;
                sh_sc_q[v]    <= Q44_UNITY;
                sh_gate_q[v]  <= 1'b0;
                act_tw_q[v]   <= '0;
                act_sc_q[v]   <= Q44_UNITY;
                act_gate_q[v] <= 1'b0;
            end
        end else begin
            if (commit_i) begin
                act_tw_q   <= sh_tw_q;
                act_sc_q   <= sh_sc_q;
                act_gate_q <= sh_gate_q;
            end
            if (we_i) begin
                sh_tw_q[widx_i]   <= wtw_i;
                sh_sc_q[widx_i]   <= wsc_i;
                sh_gate_q[widx_i] <= wgate_i;
            end
        end
    end

    assign act_tw_o   = act_tw_q;
    assign act_sc_o   = act_sc_q;
    assign act_gate_o = act_gate_q;
    assign sh_gate_o  = sh_gate_q;

endmodule

// File: rtl/mod_voice_scheduler.sv
// Time-shares one external phase modulator across all voices, one per cycle.
// Pipeline per voice: fetch (mod_rd_*) -> apply (pm_*) -> result (out_*).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sample_tick         frame start request (ignored and flagged when busy)
//   cfg_*               shadow configuration write port
//   mod_rd_en/voice     modulator sample fetch, data back one cycle later
//   mod_rd_data         fetched modulator sample (signed Q WI.WF)
//   pm_*                operands to the shared phase modulator
//   pm_result           modulator result, combinational from pm_*
//   out_valid/voice     per-voice result strobe and index
//   out_tuning_word     registered modulated tuning word
//   frame_done          pulses with the last voice's result
//   busy                frame in progress
//   overrun, ovr_clr    sticky dropped-tick flag and its clear
module mod_voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int WI         = 2,
    parameter int WF         = 16,
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int VIDX_W     = VIDX_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                cfg_we,
    input  logic [VIDX_W-1:0]   cfg_voice,
    input  logic [NUM_BITS-1:0] cfg_tuning_word,
    input  logic [7:0]          cfg_mod_scalar,
    input  logic                cfg_gate,
    output logic                mod_rd_en,
    output logic [VIDX_W-1:0]   mod_rd_voice,
    input  logic [WI+WF-1:0]    mod_rd_data,
    output logic [NUM_BITS-1:0] pm_tuning_word,
    output logic [7:0]          pm_mod_scalar,
    output logic [WI+WF-1:0]    pm_mod_signal,
    input  logic [NUM_BITS-1:0] pm_result,
    output logic                out_valid,
    output logic [VIDX_W-1:0]   out_voice,
    output logic [NUM_BITS-1:0] out_tuning_word,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun,
    input  logic                ovr_clr
);

    localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

    sched_state_e state_q;

    logic                mod_rd_en_q;
    logic [VIDX_W-1:0]   mod_rd_voice_q;
    logic                ap_v_q;
    logic [VIDX_W-1:0]   ap_idx_q;
    logic                out_valid_q;
    logic [VIDX_W-1:0]   out_voice_q;
    logic [NUM_BITS-1:0] out_tw_q;
    logic                frame_done_q;
    logic                overrun_q;

    logic [NUM_VOICES-1:0][NUM_BITS-1:0] act_tw;
    logic [NUM_VOICES-1:0][7:0]          act_sc;
    logic [NUM_VOICES-1:0]               act_gate;
    logic [NUM_VOICES-1:0]               sh_gate;

    logic                tick_acc;
    logic [VIDX_W-1:0]   nxt_voice;
    logic                ap_on;

    assign tick_acc  = sample_tick && (state_q == ST_IDLE);
    assign nxt_voice = mod_rd_voice_q + 1'b1;

    voice_cfg_bank #(
        .NUM_BITS   (NUM_BITS),
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W)
    ) u_bank (
        .clk_i      (clk),
        .rst_i      (rst),
        .we_i       (cfg_we),
        .widx_i     (cfg_voice),
        .wtw_i      (cfg_tuning_word),
        .wsc_i      (cfg_mod_scalar),
        .wgate_i    (cfg_gate),
        .commit_i   (tick_acc),
        .act_tw_o   (act_tw),
        .act_sc_o   (act_sc),
        .act_gate_o (act_gate),
        .sh_gate_o  (sh_gate)
    );

    // Apply stage: operands go straight out so the modulator result
    // can be captured on the same edge.
    assign ap_on          = ap_v_q && act_gate[ap_idx_q];
    assign pm_tuning_word = ap_on ? act_tw[ap_idx_q] : '0;
    assign pm_mod_scalar  = ap_on ? act_sc[ap_idx_q] : '0;
    assign pm_mod_signal  = ap_on ? mod_rd_data      : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mod_rd_en_q    <= 1'b0;
            mod_rd_voice_q <= '0;
            ap_v_q         <= 1'b0;
            ap_idx_q       <= '0;
            out_valid_q    <= 1'b0;
            out_voice_q    <= '0;
            out_tw_q       <= '0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            // Result stage
            out_valid_q  <= ap_v_q;
            out_voice_q  <= ap_v_q ? ap_idx_q : '0;
            out_tw_q     <= ap_on ? pm_result : '0;
            frame_done_q <= ap_v_q && (ap_idx_q == LAST_V);

            // Apply stage follows whatever was fetched last cycle
            ap_v_q   <= (state_q == ST_RUN);
            ap_idx_q <= (state_q == ST_RUN) ? mod_rd_voice_q : '0;

            // A dropped tick outranks a clear in the same cycle
            if (sample_tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state_q        <= ST_RUN;
                        // Active bank is loaded on this edge; read
                        // voice 0's gate from the shadow it copies.
                        mod_rd_en_q    <= sh_gate[0];
                        mod_rd_voice_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (mod_rd_voice_q == LAST_V) begin
                        state_q        <= ST_DRAIN;
                        mod_rd_en_q    <= 1'b0;
                        mod_rd_voice_q <= '0;
                    end else begin
                        mod_rd_en_q    <= act_gate[nxt_voice];
                        mod_rd_voice_q <= nxt_voice;
                    end
                end
                ST_DRAIN: begin
                    if (frame_done_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mod_rd_en       = mod_rd_en_q;
    assign mod_rd_voice    = mod_rd_voice_q;
    assign out_valid       = out_valid_q;
    assign out_voice       = out_voice_q;
    assign out_tuning_word = out_tw_q;
    assign frame_done      = frame_done_q;
    assign busy            = (state_q != ST_IDLE);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_mod_voice_scheduler.sv
// Directed bench for mod_voice_scheduler with a behavioural phase modulator.
// Drives and samples on the falling edge; all expectations are hand-set.
module tb_mod_voice_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_voice = '0;
    logic [31:0] cfg_tuning_word = '0;
    logic [7:0]  cfg_mod_scalar = '0;
    logic        cfg_gate = 1'b0;
    logic        mod_rd_en;
    logic [2:0]  mod_rd_voice;
    logic [17:0] mod_rd_data = '0;
    logic [31:0] pm_tuning_word;
    logic [7:0]  pm_mod_scalar;
    logic [17:0] pm_mod_signal;
    logic [31:0] pm_result;
    logic        out_valid;
    logic [2:0]  out_voice;
    logic [31:0] out_tuning_word;
    logic        frame_done;
    logic        busy;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    int total = 0;
    int bad = 0;

    logic [17:0] mem   [N];
    logic        e_gate[N];
    logic [31:0] e_tw  [N];
    logic [7:0]  e_sc  [N];
    logic [31:0] e_res [N];
    logic        ovr_exp = 1'b0;

    always #5 clk = ~clk;

    mod_voice_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .sample_tick     (sample_tick),
        .cfg_we          (cfg_we),
        .cfg_voice       (cfg_voice),
        .cfg_tuning_word (cfg_tuning_word),
        .cfg_mod_scalar  (cfg_mod_scalar),
        .cfg_gate        (cfg_gate),
        .mod_rd_en       (mod_rd_en),
        .mod_rd_voice    (mod_rd_voice),
        .mod_rd_data     (mod_rd_data),
        .pm_tuning_word  (pm_tuning_word),
        .pm_mod_scalar   (pm_mod_scalar),
        .pm_mod_signal   (pm_mod_signal),
        .pm_result       (pm_result),
        .out_valid       (out_valid),
        .out_voice       (out_voice),
        .out_tuning_word (out_tuning_word),
        .frame_done      (frame_done),
        .busy            (busy),
        .overrun         (overrun),
        .ovr_clr         (ovr_clr)
    );

    // Modulator sample memory: one-cycle read latency
    always @(posedge clk) begin
        if (mod_rd_en) mod_rd_data <= mem[mod_rd_voice];
    end

    // tw * (1 + scalar(Q4.4) * signal(signed Q2.16))
    function automatic logic [31:0] pm_model(
        input logic [31:0] tw,
        input logic [7:0]  sc,
        input logic [17:0] sg
    );
        longint p;
        p = longint'(tw) * longint'(sc) * longint'($signed(sg));
        return tw + 32'(p >>> 20);
    endfunction

    assign pm_result = pm_model(pm_tuning_word, pm_mod_scalar,
                                pm_mod_signal);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wr_cfg(input logic [2:0] v, input logic [31:0] tw,
                          input logic [7:0] sc, input logic g);
        cfg_we = 1'b1;
        cfg_voice = v;
        cfg_tuning_word = tw;
        cfg_mod_scalar = sc;
        cfg_gate = g;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Starts a frame at the current falling edge (cycle T) and checks
    // cycles T+1..T+N+3. t2/t3: extra ticks, clr_at: ovr_clr,
    // rst_at: reset cycle (0 = none).
    task automatic run_frame(input int t2, input int t3, input int clr_at,
                             input int rst_at, input bit wr,
                             input logic [2:0] wv, input logic [31:0] wtw,
                             input logic [7:0] wsc, input logic wg);
        bit live;
        int v;
        sample_tick = 1'b1;
        if (wr) begin
            cfg_we = 1'b1;
            cfg_voice = wv;
            cfg_tuning_word = wtw;
            cfg_mod_scalar = wsc;
            cfg_gate = wg;
        end
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            live = (rst_at == 0) || (k <= rst_at);
            chk($sformatf("busy k%0d", k), busy, live && k <= N + 2);
            chk($sformatf("rd_en k%0d", k), mod_rd_en,
                live && k <= N && e_gate[k-1]);
            if (live && k <= N)
                chk($sformatf("rd_voice k%0d", k), mod_rd_voice, k - 1);
            if (live && k >= 2 && k <= N + 1) begin
                v = k - 2;
                chk($sformatf("pm_tw k%0d", k), pm_tuning_word,
                    e_gate[v] ? e_tw[v] : 32'h0);
                chk($sformatf("pm_sc k%0d", k), pm_mod_scalar,
                    e_gate[v] ? e_sc[v] : 8'h0);
                chk($sformatf("pm_sig k%0d", k), pm_mod_signal,
                    e_gate[v] ? mem[v] : 18'h0);
            end else begin
                chk($sformatf("pm_zero k%0d", k),
                    {pm_tuning_word, pm_mod_scalar, pm_mod_signal}, 0);
            end
            chk($sformatf("valid k%0d", k), out_valid,
                live && k >= 3 && k <= N + 2);
            if (live && k >= 3 && k <= N + 2) begin
                chk($sformatf("voice k%0d", k), out_voice, k - 3);
                chk($sformatf("res k%0d", k), out_tuning_word, e_res[k-3]);
            end else if (!live) begin
                chk($sformatf("out_zero k%0d", k),
                    {out_voice, out_tuning_word}, 0);
            end
            chk($sformatf("done k%0d", k), frame_done, live && k == N + 2);
            chk($sformatf("ovr k%0d", k), overrun, ovr_exp);
            cfg_we = 1'b0;
            sample_tick = (k == t2) || (k == t3);
            ovr_clr = (k == clr_at);
            rst = (k == rst_at);
            if (rst) ovr_exp = 1'b0;
            else if (sample_tick && live && k <= N + 2) ovr_exp = 1'b1;
            else if (ovr_clr) ovr_exp = 1'b0;
        end
    endtask

    task automatic set_exp(input int v, input logic g, input logic [31:0] tw,
                           input logic [7:0] sc, input logic [31:0] res);
        e_gate[v] = g;
        e_tw[v] = tw;
        e_sc[v] = sc;
        e_res[v] = res;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i] = 18'h0;
            set_exp(i, 1'b0, 32'h0, 8'h10, 32'h0);
        end
        mem[0] = 18'h10000;
        mem[2] = 18'h08000;
        mem[5] = 18'h30000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst rd", {mod_rd_en, mod_rd_voice}, 0);
        chk("rst pm", {pm_tuning_word, pm_mod_scalar, pm_mod_signal}, 0);
        chk("rst out", {out_valid, out_voice, out_tuning_word}, 0);
        chk("rst flags", {frame_done, overrun}, 0);
        rst = 1'b0;
        @(negedge clk);

        // All voices gated off
        run_frame(0, 0, 0, 0, 1'b0, 3'd0, 32'h0, 8'h0, 1'b0);

        // Voices 0, 2 and 5 on
        wr_cfg(3'd0, 32'h0100_0000, 8'h10, 1'b1);
        wr_cfg(3'd2, 32'h0040_0000, 8'h20, 1'b1);
        wr_cfg(3'd5, 32'h1000_0000, 8'h08, 1'b1);
        set_exp(0, 1'b1, 32'h0100_0000, 8'h10, 32'h0200_0000);
        set_exp(2, 1'b1, 32'h0040_0000, 8'h20, 32'h0080_0000);
        set_exp(5, 1'b1, 32'h1000_0000, 8'h08, 32'h0800_0000);

        // Ticks at T+5 and T+7 dropped; clear at T+7 loses to the set
        run_frame(5, 7, 7, 0, 1'b0, 3'd0, 32'h0, 8'h0, 1'b0);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        chk("ovr cleared", overrun, 0);

        // Write on the tick cycle: old value this frame, new one next
        run_frame(0, 0, 0, 0, 1'b1, 3'd2, 32'h0020_0000, 8'h20, 1'b1);
        set_exp(2, 1'b1, 32'h0020_0000, 8'h20, 32'h0040_0000);
        run_frame(0, 0, 0, 0, 1'b0, 3'd0, 32'h0, 8'h0, 1'b0);

        // Reset in cycle T+4 aborts the frame
        run_frame(0, 0, 0, 4, 1'b0, 3'd0, 32'h0, 8'h0, 1'b0);

        // Banks were reset too: a new frame is all gated off
        for (int i = 0; i < N; i++)
            set_exp(i, 1'b0, 32'h0, 8'h10, 32'h0);
        run_frame(0, 0, 0, 0, 1'b0, 3'd0, 32'h0, 8'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_voice_scheduler.md
MOD_VOICE_SCHEDULER -- requirements
Module: mod_voice_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_BITS, default 32, tuning word width; WI, default 2, mod-signal integer bits; WF, default 16, mod-signal fraction bits; NUM_VOICES, default 8, voice count; VIDX_W, default 3, voice index width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be, in this order:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_tick  in  1  one-cycle frame start request
- cfg_we  in  1  configuration write strobe
- cfg_voice  in  VIDX_W  voice being written
- cfg_tuning_word  in  NUM_BITS  base tuning word
- cfg_mod_scalar  in  8  modulation depth, unsigned Q4.4
- cfg_gate  in  1  voice active
- mod_rd_en  out  1  modulator sample fetch
- mod_rd_voice  out  VIDX_W  voice fetched
- mod_rd_data  in  WI+WF  modulator sample, valid the cycle after mod_rd_en
- pm_tuning_word  out  NUM_BITS  to shared phase modulator
- pm_mod_scalar  out  8  to shared phase modulator
- pm_mod_signal  out  WI+WF  to shared phase modulator
- pm_result  in  NUM_BITS  modulated tuning word returned combinationally
- out_valid  out  1  result strobe
- out_voice  out  VIDX_W  result voice index
- out_tuning_word  out  NUM_BITS  modulated tuning word
- frame_done  out  1  pulse with the last result of a frame
- busy  out  1  frame in progress
- overrun  out  1  sticky flag: tick dropped
- ovr_clr  in  1  clears overrun

Function
REQ-004 The block SHALL time-share one external phase modulator across NUM_VOICES voices, one voice per cycle, pipelined.
REQ-005 Config writes SHALL go to a shadow bank in the write cycle; shadow SHALL copy to the active bank only when a sample_tick is accepted, so a frame always sees one consistent configuration.
REQ-006 cfg_we coincident with an accepted sample_tick SHALL update the shadow only; the write takes effect the following frame.
REQ-007 FSM states SHALL be IDLE, RUN and DRAIN. IDLE -> RUN on sample_tick. RUN -> DRAIN after voice NUM_VOICES-1 is fetched. DRAIN -> IDLE once the last result has been emitted.
REQ-008 The tick accepted in cycle T SHALL produce fetches for voices 0..N-1 in cycles T+1..T+N, apply in T+2..T+N+1, and out_valid in T+3..T+N+2, in ascending voice order.
REQ-009 In the apply cycle, pm_* SHALL carry that voice's active tuning word, mod scalar and mod_rd_data; out_tuning_word SHALL register pm_result.
REQ-010 Inactive voices (gate=0) SHALL not assert mod_rd_en, SHALL drive pm_* to zero, and SHALL still emit out_valid with out_tuning_word=0.
REQ-011 frame_done SHALL pulse together with the out_valid of voice NUM_VOICES-1.
REQ-012 busy SHALL be high from T+1 through T+N+2 inclusive.
REQ-013 sample_tick while busy SHALL be ignored and SHALL set overrun. A new tick SHALL be accepted at T+N+3 at the earliest.
REQ-014 overrun SHALL be cleared by ovr_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-015 pm_* SHALL be zero outside apply cycles.

Reset
REQ-016 Reset SHALL clear these outputs to 0: mod_rd_en, mod_rd_voice, pm_*, out_valid, out_voice, out_tuning_word, frame_done, busy, overrun.
REQ-017 Reset SHALL set the FSM to IDLE.
REQ-018 Reset SHALL set both banks to tuning word 0, mod scalar 8'h10 (1.0) and gate 0.
REQ-019 Reset mid-frame SHALL abort the frame immediately, with no further out_valid and no frame_done.

Structure
REQ-020 synth_pkg SHALL hold the state enum, the NUM_VOICES/VIDX_W defaults and the constant Q44_UNITY=8'h10.
REQ-021 The shadow/active register file SHALL be the single sub-module voice_cfg_bank.
REQ-022 The phase modulator SHALL remain outside the block.

Verification
REQ-023 Voice 0: gate=1, tuning word 32'h0100_0000, scalar 8'h10, mod_rd_data 18'h10000; one tick -> out_voice 0 with 32'h0200_0000 at T+3.
REQ-024 All voices gated off; tick -> 8 out_valid of 0, no mod_rd_en, frame_done at T+10, busy T+1..T+10.
REQ-025 Second tick at T+5 -> ignored and overrun=1. ovr_clr and a new overrun in the same cycle -> overrun stays 1.
REQ-026 cfg_we changes voice 2 in the same cycle as the tick -> the frame uses the old value, and the next frame uses the new value.
REQ-027 rst asserted at T+4 -> all outputs 0 the next cycle, and no frame_done.
REQ-028 Back-to-back ticks at T and T+11 -> two complete frames, with no overrun.
